// File: rtl/uart_fsm_rx.sv
// rtl/uart_fsm_rx.sv - UART 8N1 receive FSM with centre sampling and framing-error detection.
// Optional even-parity check enabled by defining UART_RX_PARITY_EN.
module uart_fsm_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       rx_busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_TC = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BREAK
    } state_t;
`endif

    state_t        state, state_n;
    logic          rxd_m, rxd_s;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    data_out_n;
    logic          rx_done_n, frame_err_n;
`ifdef UART_RX_PARITY_EN
    logic          par_bit, par_bit_n;
    logic          parity_err_n;
`endif

    // Two-flop synchronizer; idles high so reset does not look like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data_out   <= '0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            clk_cnt    <= clk_cnt_n;
            bit_idx    <= bit_idx_n;
            shift      <= shift_n;
            data_out   <= data_out_n;
            rx_done    <= rx_done_n;
            frame_err  <= frame_err_n;
`ifdef UART_RX_PARITY_EN
            par_bit    <= par_bit_n;
            parity_err <= parity_err_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        clk_cnt_n    = clk_cnt;
        bit_idx_n    = bit_idx;
        shift_n      = shift;
        data_out_n   = data_out;
        rx_done_n    = 1'b0;
        frame_err_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n    = par_bit;
        parity_err_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                clk_cnt_n = '0;
                bit_idx_n = '0;
                if (!rxd_s) begin
                    state_n = START;
                end
            end
            START: begin
                if (clk_cnt == HALF_TC) begin
                    clk_cnt_n = '0;
                    // Line back high at the start-bit centre means it was a glitch
                    state_n   = rxd_s ? IDLE : DATA;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (clk_cnt == BIT_TC) begin
                    clk_cnt_n        = '0;
                    shift_n[bit_idx] = rxd_s;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt == BIT_TC) begin
                    clk_cnt_n = '0;
                    par_bit_n = rxd_s;
                    state_n   = STOP;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
`endif
            STOP: begin
                if (clk_cnt == BIT_TC) begin
                    clk_cnt_n = '0;
                    if (rxd_s) begin
                        data_out_n   = shift;
                        rx_done_n    = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_n = ^{shift, par_bit};
`endif
                        state_n      = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = BREAK;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            BREAK: begin
                // A held-low line must go high before another start edge counts
                clk_cnt_n = '0;
                if (rxd_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_fsm_rx.sv
// tb/tb_uart_fsm_rx.sv - Scoreboard testbench for uart_fsm_rx with randomized frames.
module tb_uart_fsm_rx;

    localparam int C = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = C * NBITS;
    localparam int LAT   = 2 + C / 2 + (NBITS - 1) * C + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] data_out;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_fsm_rx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .data_out  (data_out),
        .rx_done   (rx_done),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] data;
        bit         perr;
    } exp_t;

    exp_t       exp_q[$];
    int         start_q[$];
    int         done_cyc[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT output event must match the oldest expected frame outcome
    always @(negedge clk) begin
        exp_t e;
        int   s;
        if (!rst && (rx_done || frame_err)) begin
            chk("done_err_exclusive", 32'(rx_done & frame_err), 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: rx_done=%0d frame_err=%0d with no frame pending", rx_done, frame_err);
            end else begin
                e = exp_q.pop_front();
                s = start_q.pop_front();
                chk("event_is_frame_err", 32'(frame_err), 32'(e.err));
                chk("data_out", 32'(data_out), 32'(e.data));
`ifdef UART_RX_PARITY_EN
                chk("parity_err", 32'(parity_err & rx_done), 32'(e.perr));
`endif
                if (rx_done) begin
                    done_cyc.push_back(cyc);
                    n_checks++;
                    if ((cyc - s) < LAT - 1 || (cyc - s) > LAT + 1) begin
                        n_fail++;
                        $display("FAIL latency: got %0d cycles expected %0d +-1", cyc - s, LAT);
                    end
                end
            end
        end
    end

    task automatic hold_bit(input logic b);
        rxd = b;
        repeat (C) @(posedge clk);
        #1;
    endtask

    // Sends one frame and records the outcome the frame rules predict
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit pbit);
        exp_t e;
        e.err  = !stop;
        e.perr = ^{d, pbit};
        e.data = stop ? d : last_good;
        if (stop) last_good = d;
        exp_q.push_back(e);
        start_q.push_back(cyc);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit(pbit);
`endif
        hold_bit(stop);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2 * FRAME) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit         st;
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_out", 32'(data_out), 32'h00);
        chk("reset_rx_done", 32'(rx_done), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_rx_busy", 32'(rx_busy), 32'd0);
        rst = 1'b0;
        idle(4);

        send_frame(8'hAA, 1'b1, 1'b0);
        idle(3);
        drain("drain_aa");

        done_cyc.delete();
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(3);
        drain("drain_b2b");
        chk("b2b_count", 32'(done_cyc.size()), 32'd3);
        if (done_cyc.size() == 3) begin
            chk("b2b_spacing1", 32'(done_cyc[1] - done_cyc[0]), 32'(FRAME));
            chk("b2b_spacing2", 32'(done_cyc[2] - done_cyc[1]), 32'(FRAME));
        end

        rxd = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rxd = 1'b1;
        @(posedge clk);
        #1;
        chk("glitch_busy_high", 32'(rx_busy), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("glitch_busy_low", 32'(rx_busy), 32'd0);

        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk("break_busy", 32'(rx_busy), 32'd1);
        idle(5);
        chk("break_exit", 32'(rx_busy), 32'd0);
        drain("drain_ferr");

        for (int k = 0; k < 20; k++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 4) != 0);
            send_frame(d, st, 1'($urandom));
            if (!st) begin
                repeat ($urandom_range(0, 40)) @(posedge clk);
                #1;
                idle(4);
            end else begin
                idle($urandom_range(0, 3));
            end
        end
        drain("drain_random");
        if (last_good == 8'h00) begin
            send_frame(8'h5A, 1'b1, 1'b0);
            idle(2);
            drain("drain_prereset");
        end

        d = 8'hC3;
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(d[i]);
        rxd = d[4];
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_data_out", 32'(data_out), 32'h00);
        chk("async_rst_rx_busy", 32'(rx_busy), 32'd0);
        chk("async_rst_rx_done", 32'(rx_done), 32'd0);
        chk("async_rst_frame_err", 32'(frame_err), 32'd0);
        rxd = 1'b1;
        last_good = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(3);
        drain("drain_81");
        chk("final_data_out", 32'(data_out), 32'h81);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(3);
        drain("drain_parity");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
